// File: rtl/crg_pkg.sv
// Shared definitions for the clock/reset generation layer: sequencer state
// encoding and the width of the shared phase counter.
package crg_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    HOLD      = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3
  } seq_state_e;

  localparam int LOSS_CNT_W = 8;

  // Bits needed to hold (max phase length - 1); never narrower than one bit.
  function automatic int cnt_width(input int hold_cycles, input int stagger_cycles,
                                   input int lock_filter);
    int m;
    m = hold_cycles;
    if (stagger_cycles > m) m = stagger_cycles;
    if (lock_filter > m) m = lock_filter;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Two-stage synchroniser for a single asynchronous level, cleared by the
// asynchronous reset so a stale sample never survives a reset.
module sync_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/crg_reset_seq.sv
// Reset sequencer: qualifies PLL lock, holds all domains in reset, then
// releases them one by one with a fixed stagger. Counts lock-loss events.
module crg_reset_seq
  import crg_pkg::*;
#(
  parameter int NUM_DOMAINS    = 4,
  parameter int LOCK_FILTER    = 8,
  parameter int HOLD_CYCLES    = 1024,
  parameter int STAGGER_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pll_locked,
  input  logic                   soft_reset,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   all_ready,
  output logic                   lock_lost,
  output logic [LOSS_CNT_W-1:0]  lock_loss_cnt,
  output logic [2:0]             seq_state
);

  localparam int CW = cnt_width(HOLD_CYCLES, STAGGER_CYCLES, LOCK_FILTER);
  localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  // The shared down-counter is loaded with (phase length - 1) and the phase
  // ends on the edge that sees it at zero.
  localparam logic [CW-1:0] FILTER_LOAD  = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] HOLD_LOAD    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAGGER_LOAD = CW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX     = IW'(NUM_DOMAINS - 1);

  seq_state_e    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          lock_s;
  logic          cnt_done;
  logic          loss;

  sync_bit u_lock_sync (
    .clk (clk),
    .rst (reset),
    .d   (pll_locked),
    .q   (lock_s)
  );

  assign cnt_done  = (cnt == '0);
  assign loss      = (state != WAIT_LOCK) && !lock_s;
  assign seq_state = state;

  // NOTE: every register here is updated with <= so all branches see the
  // pre-edge values of state, cnt and idx regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= WAIT_LOCK;
      cnt           <= '0;
      idx           <= '0;
      rst_out       <= '1;
      all_ready     <= 1'b0;
      lock_lost     <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      lock_lost <= 1'b0;
      if (loss) begin
        // Lock loss takes priority over a simultaneous soft reset.
        state     <= WAIT_LOCK;
        cnt       <= FILTER_LOAD;
        idx       <= '0;
        rst_out   <= '1;
        all_ready <= 1'b0;
        lock_lost <= 1'b1;
        if (lock_loss_cnt != '1) lock_loss_cnt <= lock_loss_cnt + 1'b1;
      end else if (soft_reset && (state != WAIT_LOCK)) begin
        state     <= HOLD;
        cnt       <= HOLD_LOAD;
        idx       <= '0;
        rst_out   <= '1;
        all_ready <= 1'b0;
      end else begin
        case (state)
          WAIT_LOCK: begin
            if (!lock_s) begin
              cnt <= FILTER_LOAD;
            end else if (cnt_done) begin
              state <= HOLD;
              cnt   <= HOLD_LOAD;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          HOLD: begin
            if (cnt_done) begin
              state   <= RELEASE;
              cnt     <= STAGGER_LOAD;
              idx     <= '0;
              rst_out <= rst_out << 1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          RELEASE: begin
            if (cnt_done) begin
              cnt <= STAGGER_LOAD;
              // Shifting a zero in releases the next domain and can never
              // re-assert one that is already released.
              if (idx != LAST_IDX) begin
                idx     <= idx + 1'b1;
                rst_out <= rst_out << 1;
              end else begin
                state     <= RUN;
                all_ready <= 1'b1;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          RUN: begin
            rst_out <= '0;
          end
          default: begin
            state <= WAIT_LOCK;
            cnt   <= FILTER_LOAD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crg_reset_seq.sv
// Directed bench for crg_reset_seq (3 domains, filter 4, hold 10, stagger 3);
// expected edge numbers are queued when stimulus is applied, popped on observation.
module tb_crg_reset_seq;
  import crg_pkg::*;

  localparam int N  = 3;
  localparam int LF = 4;
  localparam int HC = 10;
  localparam int SC = 3;

  localparam int W_ALL_READY = 3;
  localparam int W_ALL_RESET = 4;
  localparam int W_HOLD      = 5;
  localparam int W_WAIT_LOCK = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pll_locked = 1'b0;
  logic         soft_reset = 1'b0;
  logic [N-1:0] rst_out;
  logic         all_ready;
  logic         lock_lost;
  logic [7:0]   lock_loss_cnt;
  logic [2:0]   seq_state;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_cmp  = 0;
  int n_err  = 0;
  int edge_n = 0;
  int base   = 0;

  crg_reset_seq #(
    .NUM_DOMAINS    (N),
    .LOCK_FILTER    (LF),
    .HOLD_CYCLES    (HC),
    .STAGGER_CYCLES (SC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pll_locked    (pll_locked),
    .soft_reset    (soft_reset),
    .rst_out       (rst_out),
    .all_ready     (all_ready),
    .lock_lost     (lock_lost),
    .lock_loss_cnt (lock_loss_cnt),
    .seq_state     (seq_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic expect_val(input string tag, input logic [31:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_entry_t e;
    e = sb.pop_front();
    n_cmp++;
    assert (obs === e.exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
    end
  endtask

  function automatic bit cond(input int which);
    case (which)
      0, 1, 2:     return rst_out[which] == 1'b0;
      W_ALL_READY: return all_ready == 1'b1;
      W_ALL_RESET: return rst_out == '1;
      W_HOLD:      return seq_state == 3'd1;
      W_WAIT_LOCK: return seq_state == 3'd0;
      default:     return 1'b0;
    endcase
  endfunction

  // Returns the edge number (relative to base) at which the condition first
  // holds, or -1 if the budget runs out.
  task automatic wait_for(input int which, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cond(which)) begin
        at = edge_n - base;
        break;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    expect_val({tag, "_rst_out"}, 32'd7);
    check(32'(rst_out));
    expect_val({tag, "_all_ready"}, 32'd0);
    check(32'(all_ready));
    expect_val({tag, "_lock_lost"}, 32'd0);
    check(32'(lock_lost));
    expect_val({tag, "_loss_cnt"}, 32'd0);
    check(32'(lock_loss_cnt));
    expect_val({tag, "_state"}, 32'd0);
    check(32'(seq_state));
  endtask

  initial begin
    int at;
    int n_loss;
    int timeouts;

    // Cold start: reset values, then release at edges 16/19/22, ready at 25.
    pll_locked = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    base  = edge_n;
    expect_val("cold_rst0", 32'd16);
    expect_val("cold_rst1", 32'd19);
    expect_val("cold_rst2", 32'd22);
    expect_val("cold_ready", 32'd25);
    wait_for(0, 40, at);           check(at);
    wait_for(1, 10, at);           check(at);
    wait_for(2, 10, at);           check(at);
    wait_for(W_ALL_READY, 10, at); check(at);
    expect_val("cold_run_state", 32'd3);
    check(32'(seq_state));

    // Lock drop in RUN: full reassert on the 3rd edge, single pulse, count 1.
    repeat (2) @(negedge clk);
    pll_locked = 1'b0;
    base = edge_n;
    expect_val("loss_reassert", 32'd3);
    wait_for(W_ALL_RESET, 10, at); check(at);
    expect_val("loss_pulse", 32'd1);
    check(32'(lock_lost));
    expect_val("loss_cnt1", 32'd1);
    check(32'(lock_loss_cnt));
    expect_val("loss_state", 32'd0);
    check(32'(seq_state));
    @(negedge clk);
    expect_val("loss_pulse_end", 32'd0);
    check(32'(lock_lost));

    // Relock repeats the cold-start timing.
    repeat (4) @(negedge clk);
    pll_locked = 1'b1;
    base = edge_n;
    expect_val("relock_rst0", 32'd16);
    expect_val("relock_ready", 32'd25);
    wait_for(0, 40, at);           check(at);
    wait_for(W_ALL_READY, 20, at); check(at);

    // Soft reset sampled on the same edge as the lock loss: loss wins.
    repeat (2) @(negedge clk);
    pll_locked = 1'b0;
    base = edge_n;
    repeat (2) @(negedge clk);
    soft_reset = 1'b1;
    expect_val("both_state", 32'd0);
    expect_val("both_pulse", 32'd1);
    expect_val("both_cnt", 32'd2);
    expect_val("both_rst_out", 32'd7);
    @(negedge clk);
    soft_reset = 1'b0;
    check(32'(seq_state));
    check(32'(lock_lost));
    check(32'(lock_loss_cnt));
    check(32'(rst_out));

    // Glitch on the last filter edge: pll low sampled at edge 4 makes lock_s
    // low at edge 6, so the filter refills from there and release slips by LF.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    pll_locked = 1'b1;
    reset = 1'b0;
    base = edge_n;
    repeat (3) @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    expect_val("glitch_rst0", 32'd20);
    wait_for(0, 40, at); check(at);

    // Soft reset sampled at edge 13 (mid-HOLD): release moves to edge 23.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    base = edge_n;
    repeat (12) @(negedge clk);
    soft_reset = 1'b1;
    @(negedge clk);
    soft_reset = 1'b0;
    expect_val("soft_hold_state", 32'd1);
    check(32'(seq_state));
    expect_val("soft_hold_rst0", 32'd23);
    expect_val("soft_hold_ready", 32'd32);
    wait_for(0, 40, at);           check(at);
    wait_for(W_ALL_READY, 20, at); check(at);

    // Soft reset in RUN: all domains back in reset next edge, rst_out[0]
    // released 10 edges after that.
    repeat (2) @(negedge clk);
    soft_reset = 1'b1;
    base = edge_n;
    @(negedge clk);
    soft_reset = 1'b0;
    expect_val("soft_run_rst_out", 32'd7);
    check(32'(rst_out));
    expect_val("soft_run_ready", 32'd0);
    check(32'(all_ready));
    expect_val("soft_run_rst0", 32'd11);
    wait_for(0, 20, at); check(at);

    // 300 forced lock losses: the counter saturates at 255.
    n_loss   = 0;
    timeouts = 0;
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      wait_for(W_WAIT_LOCK, 10, at);
      if (at < 0) timeouts++;
      n_loss++;
      if (n_loss >= 253 && n_loss <= 257) begin
        expect_val("sat_cnt", (n_loss > 255) ? 32'd255 : 32'(n_loss));
        check(32'(lock_loss_cnt));
      end
      pll_locked = 1'b1;
      wait_for(W_HOLD, 20, at);
      if (at < 0) timeouts++;
    end
    expect_val("sat_final", 32'd255);
    check(32'(lock_loss_cnt));
    expect_val("sat_timeouts", 32'd0);
    check(32'(timeouts));

    // Async reset mid-RELEASE clears everything before any clock edge.
    expect_val("async_reach_release", 32'd1);
    wait_for(0, 30, at);
    check(32'(at > 0));
    #1 reset = 1'b1;
    #1 check_idle("async");
    // Synchroniser must also be cleared: cold-start timing again.
    @(negedge clk);
    reset = 1'b0;
    base = edge_n;
    expect_val("after_async_rst0", 32'd16);
    wait_for(0, 40, at); check(at);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
